// File: rtl/pipe_ctrl_pkg.sv
// Shared defines, state encodings and stall patterns for pipe_ctrl.
// Stall bus: bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM, bit4 MEM/WB.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define STALL_BUS      4:0
`define STOP           1'b1
`define NOSTOP         1'b0
`define EXC_CODE_BUS   4:0
`define INST_ADDR_BUS  31:0
`define EXC_ERET       5'h1e
`define PC_ST_IDLE     2'd0
`define PC_ST_DIV_BUSY 2'd1
`define PC_ST_DIV_DONE 2'd2
`endif

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = `PC_ST_IDLE,
    S_DIV_BUSY = `PC_ST_DIV_BUSY,
    S_DIV_DONE = `PC_ST_DIV_DONE
  } pc_state_e;

  localparam logic [4:0] STALL_NONE = {5{`NOSTOP}};
  localparam logic [4:0] STALL_ALL  = {5{`STOP}};
  localparam logic [4:0] STALL_DIV  =
    {`NOSTOP, `STOP, `STOP, `STOP, `STOP};
  // ID/EXE held while EXE/MEM runs: a bubble enters EXE.
  localparam logic [4:0] STALL_LOAD =
    {`NOSTOP, `NOSTOP, `STOP, `STOP, `STOP};

  localparam logic [4:0] EXC_ERET_CODE = `EXC_ERET;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Performance counters: stalled-PC cycles (saturating) and flush cycles.
// Ports: clk, rst (async high), stall_pc, flush in; two counters out.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_cnt
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_cnt    = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle divider watchdog.
// Inputs: hazard/divider/exception requests; outputs: stall, flush,
// flush_pc, div_cancel, div_timeout. STALL_PERF_EN adds perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
  parameter int          DIV_CYCLES = 34
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  input  logic                  stallreq_id,
  input  logic                  div_start,
  input  logic                  div_ready,
  input  logic                  stallreq_mem,
  input  logic                  exc_valid,
  input  logic [`EXC_CODE_BUS]  exc_code,
  input  logic [`INST_ADDR_BUS] cp0_epc,
  output logic [`STALL_BUS]     stall,
  output logic                  flush,
  output logic [`INST_ADDR_BUS] flush_pc,
  output logic                  div_cancel,
  output logic                  div_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [15:0]           perf_flush_cnt
`endif
);

  // Last busy cycle index before the watchdog fires.
  localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);

  pc_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        cancel;
  logic        div_hold;
  logic [4:0]  stall_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    cancel   = 1'b0;
    div_hold = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_hold = div_start;
        if (div_start && !exc_valid) begin
          state_d = S_DIV_BUSY;
          cnt_d   = '0;
        end
      end
      S_DIV_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (exc_valid) begin
          cancel  = 1'b1;
          state_d = S_IDLE;
        end else if (div_ready) begin
          state_d = S_DIV_DONE;
        end else if (cnt_q == DIV_LAST) begin
          // Watchdog: drop the divide and let the pipe run again.
          cancel  = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_hold = 1'b1;
        end
      end
      S_DIV_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_raw = STALL_NONE;
    if (exc_valid)         stall_raw = STALL_NONE;
    else if (stallreq_mem) stall_raw = STALL_ALL;
    else if (div_hold)     stall_raw = STALL_DIV;
    else if (stallreq_id)  stall_raw = STALL_LOAD;
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign stall       = cpu_rst ? STALL_NONE : stall_raw;
  assign flush       = exc_valid & ~cpu_rst;
  assign div_cancel  = cancel & ~cpu_rst;
  assign div_timeout = tmo_q;
  assign flush_pc    = (!cpu_rst && exc_code == EXC_ERET_CODE)
                       ? cp0_epc : EXC_VECTOR;

`ifdef STALL_PERF_EN
  pipe_perf_cnt u_perf (
    .clk               (cpu_clk_50M),
    .rst               (cpu_rst),
    .stall_pc          (stall[0] == `STOP),
    .flush             (flush),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] VEC = 32'h0000_0100;
  localparam int          DC  = 34;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic        stallreq_id, div_start, div_ready;
  logic        stallreq_mem, exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] cp0_epc;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        div_cancel, div_timeout;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  pipe_ctrl #(.EXC_VECTOR(VEC), .DIV_CYCLES(DC)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst      (cpu_rst),
    .stallreq_id  (stallreq_id),
    .div_start    (div_start),
    .div_ready    (div_ready),
    .stallreq_mem (stallreq_mem),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .div_cancel   (div_cancel),
    .div_timeout  (div_timeout)
`ifdef STALL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  task automatic clr_in();
    stallreq_id  = 0; div_start = 0; div_ready = 0;
    stallreq_mem = 0; exc_valid = 0;
    exc_code = 5'h00; cp0_epc = 32'h0;
  endtask

  task automatic nxt();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    cpu_rst = 1;
    nxt(); nxt();
    cpu_rst = 0;
  endtask

  task automatic test_reset();
    clr_in();
    cpu_rst = 1;
    #5;
    total++;
    if (stall !== 5'h00 || flush !== 1'b0 || div_cancel !== 1'b0) begin
      bad++;
      $display("FAIL reset_out stall=%b flush=%b cancel=%b want 0",
               stall, flush, div_cancel);
    end
    total++;
    if (div_timeout !== 1'b0 || flush_pc !== VEC) begin
      bad++;
      $display("FAIL reset_regs tmo=%b pc=%h want 0/%h",
               div_timeout, flush_pc, VEC);
    end
    total++;
    if (dut.state_q !== S_IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d want IDLE", dut.state_q);
    end
    nxt(); nxt();
    cpu_rst = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    stallreq_id = 1;
    exc_code = 5'h04;
    @(negedge cpu_clk_50M);
    total++;
    if (stall !== 5'b00111) begin
      bad++;
      $display("FAIL load_use got=%b want 00111", stall);
    end
    total++;
    if (flush_pc !== VEC || flush !== 1'b0) begin
      bad++;
      $display("FAIL load_use_pc pc=%h flush=%b want %h/0",
               flush_pc, flush, VEC);
    end
    nxt();
    stallreq_id = 0;
    @(negedge cpu_clk_50M);
    total++;
    if (stall !== 5'b00000) begin
      bad++;
      $display("FAIL load_use_next got=%b want 00000", stall);
    end
    nxt();
  endtask

  task automatic test_div_normal();
    do_reset();
    div_start = 1;
    @(negedge cpu_clk_50M);
    total++;
    if (stall !== 5'b01111) begin
      bad++;
      $display("FAIL div_T got=%b want 01111", stall);
    end
    nxt();
    div_start = 0;
    for (int k = 1; k <= 35; k++) begin
      div_ready = (k == 33);
      @(negedge cpu_clk_50M);
      if (k <= 32) begin
        total++;
        if (stall !== 5'b01111) begin
          bad++;
          $display("FAIL div_busy k=%0d got=%b want 01111", k, stall);
        end
      end else begin
        total++;
        if (stall !== 5'b00000) begin
          bad++;
          $display("FAIL div_rel k=%0d got=%b want 00000", k, stall);
        end
      end
      if (k == 34) begin
        total++;
        if (dut.state_q !== S_DIV_DONE) begin
          bad++;
          $display("FAIL div_done got=%0d want DONE", dut.state_q);
        end
      end
      if (k == 35) begin
        total++;
        if (dut.state_q !== S_IDLE) begin
          bad++;
          $display("FAIL div_idle got=%0d want IDLE", dut.state_q);
        end
      end
      nxt();
    end
    div_ready = 0;
  endtask

  task automatic test_div_eret();
    do_reset();
    div_start = 1;
    nxt();
    div_start = 0;
    repeat (5) nxt();
    exc_valid = 1;
    exc_code  = EXC_ERET_CODE;
    cp0_epc   = 32'h0040_0020;
    @(negedge cpu_clk_50M);
    total++;
    if (flush !== 1'b1 || flush_pc !== 32'h0040_0020) begin
      bad++;
      $display("FAIL eret_flush flush=%b pc=%h want 1/00400020",
               flush, flush_pc);
    end
    total++;
    if (div_cancel !== 1'b1 || stall !== 5'b00000) begin
      bad++;
      $display("FAIL eret_cancel cancel=%b stall=%b want 1/00000",
               div_cancel, stall);
    end
    nxt();
    clr_in();
    @(negedge cpu_clk_50M);
    total++;
    if (dut.state_q !== S_IDLE || div_cancel !== 1'b0) begin
      bad++;
      $display("FAIL eret_next state=%0d cancel=%b want IDLE/0",
               dut.state_q, div_cancel);
    end
    nxt();
  endtask

  task automatic test_timeout();
    do_reset();
    div_start = 1;
    nxt();
    div_start = 0;
    for (int k = 1; k <= DC; k++) begin
      @(negedge cpu_clk_50M);
      if (k < DC) begin
        total++;
        if (div_cancel !== 1'b0 || stall !== 5'b01111) begin
          bad++;
          $display("FAIL tmo_busy k=%0d cancel=%b stall=%b want 0/01111",
                   k, div_cancel, stall);
        end
      end else begin
        total++;
        if (div_cancel !== 1'b1 || div_timeout !== 1'b0) begin
          bad++;
          $display("FAIL tmo_hit cancel=%b tmo=%b want 1/0",
                   div_cancel, div_timeout);
        end
      end
      nxt();
    end
    @(negedge cpu_clk_50M);
    total++;
    if (div_timeout !== 1'b1 || stall !== 5'b00000) begin
      bad++;
      $display("FAIL tmo_after tmo=%b stall=%b want 1/00000",
               div_timeout, stall);
    end
    total++;
    if (dut.state_q !== S_IDLE || div_cancel !== 1'b0) begin
      bad++;
      $display("FAIL tmo_idle state=%0d cancel=%b want IDLE/0",
               dut.state_q, div_cancel);
    end
    repeat (3) nxt();
    total++;
    if (div_timeout !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky got=%b want 1", div_timeout);
    end
  endtask

  task automatic test_mem_priority();
    do_reset();
    stallreq_mem = 1; stallreq_id = 1; div_start = 1;
    @(negedge cpu_clk_50M);
    total++;
    if (stall !== 5'b11111) begin
      bad++;
      $display("FAIL mem_prio got=%b want 11111", stall);
    end
    nxt();
    div_start = 0;
    @(negedge cpu_clk_50M);
    total++;
    if (stall !== 5'b11111 || dut.state_q !== S_DIV_BUSY) begin
      bad++;
      $display("FAIL mem_busy stall=%b st=%0d want 11111/BUSY",
               stall, dut.state_q);
    end
    nxt();
    stallreq_mem = 0;
    @(negedge cpu_clk_50M);
    total++;
    if (stall !== 5'b01111) begin
      bad++;
      $display("FAIL mem_rel got=%b want 01111", stall);
    end
    nxt();
    clr_in();
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    div_start = 1;
    nxt();
    div_start = 0;
    repeat (5) nxt();
    #3;
    exc_valid = 1;
    exc_code  = EXC_ERET_CODE;
    cp0_epc   = 32'h1234_5678;
    cpu_rst   = 1;
    #1;
    total++;
    if (dut.state_q !== S_IDLE || stall !== 5'b00000) begin
      bad++;
      $display("FAIL rst_mid state=%0d stall=%b want IDLE/00000",
               dut.state_q, stall);
    end
    total++;
    if (div_cancel !== 1'b0 || flush !== 1'b0 || flush_pc !== VEC) begin
      bad++;
      $display("FAIL rst_mid_out cancel=%b flush=%b pc=%h want 0/0/%h",
               div_cancel, flush, flush_pc, VEC);
    end
    nxt();
    clr_in();
    cpu_rst = 0;
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    do_reset();
    stallreq_id = 1;
    repeat (10) nxt();
    stallreq_id = 0;
    exc_valid = 1;
    repeat (3) nxt();
    exc_valid = 0;
    @(negedge cpu_clk_50M);
    total++;
    if (perf_stall_cycles !== 32'd10) begin
      bad++;
      $display("FAIL perf_stall got=%0d want 10", perf_stall_cycles);
    end
    total++;
    if (perf_flush_cnt !== 16'd3) begin
      bad++;
      $display("FAIL perf_flush got=%0d want 3", perf_flush_cnt);
    end
    nxt();
  endtask
`endif

  // Model: mode 0 idle, 1 dividing, 2 result cycle; n = busy cycles done.
  task automatic test_random();
    int mode, n, tmo, hit, busy;
    logic [4:0]  e_stall;
    logic [31:0] e_pc;
    do_reset();
    mode = 0; n = 0; tmo = 0;
    for (int c = 0; c < 3000; c++) begin
      stallreq_id  = ($urandom_range(3) == 0);
      div_start    = ($urandom_range(3) == 0);
      div_ready    = ($urandom_range(29) == 0);
      stallreq_mem = ($urandom_range(5) == 0);
      exc_valid    = ($urandom_range(24) == 0);
      exc_code     = ($urandom_range(1) == 0) ? EXC_ERET_CODE
                                              : 5'($urandom_range(15));
      cp0_epc      = $urandom;
      busy = (mode == 1);
      hit  = busy && !exc_valid && !div_ready && (n + 1 == DC);
      if (exc_valid)         e_stall = 5'b00000;
      else if (stallreq_mem) e_stall = 5'b11111;
      else if ((mode == 0 && div_start) ||
               (busy && !div_ready && !hit))
                             e_stall = 5'b01111;
      else if (stallreq_id)  e_stall = 5'b00111;
      else                   e_stall = 5'b00000;
      e_pc = (exc_code == EXC_ERET_CODE) ? cp0_epc : VEC;
      @(negedge cpu_clk_50M);
      total++;
      if (stall !== e_stall) begin
        bad++;
        $display("FAIL rnd_stall c=%0d got=%b want %b", c, stall, e_stall);
      end
      total++;
      if (flush !== exc_valid || flush_pc !== e_pc) begin
        bad++;
        $display("FAIL rnd_flush c=%0d flush=%b pc=%h want %b/%h",
                 c, flush, flush_pc, exc_valid, e_pc);
      end
      total++;
      if (div_cancel !== 1'(busy && (exc_valid || hit))) begin
        bad++;
        $display("FAIL rnd_cancel c=%0d got=%b want %b",
                 c, div_cancel, busy && (exc_valid || hit));
      end
      total++;
      if (div_timeout !== 1'(tmo)) begin
        bad++;
        $display("FAIL rnd_tmo c=%0d got=%b want %0d", c, div_timeout, tmo);
      end
      case (mode)
        0: if (div_start && !exc_valid) begin mode = 1; n = 0; end
        1: begin
          if (exc_valid)      mode = 0;
          else if (div_ready) mode = 2;
          else if (hit)       begin mode = 0; tmo = 1; end
          else                n++;
        end
        default: mode = 0;
      endcase
      nxt();
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div_normal();
    test_div_eret();
    test_timeout();
    test_mem_priority();
    test_reset_mid_div();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have params: EXC_VECTOR, default 32'h0000_0100, exception entry PC; DIV_CYCLES, default 34, divider watchdog limit in cycles.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-high):
- cpu_clk_50M  in  1  sole clock.
- cpu_rst  in  1  asynchronous, active-high reset.
- stallreq_id  in  1  load-use hazard from ID.
- div_start  in  1  EXE issuing multi-cycle div/divu.
- div_ready  in  1  divider result valid.
- stallreq_mem  in  1  data-bus wait from MEM.
- exc_valid  in  1  MEM-stage exception/eret commit.
- exc_code  in  `EXC_CODE_BUS  cause code; `EXC_ERET selects return.
- cp0_epc  in  `INST_ADDR_BUS  return address.
- stall  out  `STALL_BUS (5)  bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM, bit4 MEM/WB; `STOP=1.
- flush  out  1  clear all pipeline registers.
- flush_pc  out  `INST_ADDR_BUS  redirect target.
- div_cancel  out  1  abort in-flight divide.
- div_timeout  out  1  sticky watchdog flag.

Function
REQ-003 SHALL run FSM states IDLE, DIV_BUSY, DIV_DONE.
REQ-004 IDLE->DIV_BUSY on div_start && !exc_valid; DIV_BUSY->DIV_DONE on div_ready; DIV_DONE->IDLE unconditionally next cycle.
REQ-005 stall SHALL be combinational, priority high to low:
- exc_valid -> 5'b00000.
- stallreq_mem -> 5'b11111.
- (div_start in IDLE) or (DIV_BUSY && !div_ready) -> 5'b01111.
- stallreq_id -> 5'b00111; bit2=STOP with bit3=NOSTOP makes ID/EXE insert a bubble.
- otherwise 5'b00000.
REQ-006 DIV_DONE SHALL not stall for the divide.
REQ-007 flush SHALL equal exc_valid in the same cycle (zero latency).
REQ-008 flush_pc SHALL be cp0_epc when exc_code==`EXC_ERET, else EXC_VECTOR.
REQ-009 exc_valid in DIV_BUSY SHALL pulse div_cancel for that cycle and force the next state to IDLE.
REQ-010 exc_valid and div_ready together SHALL give flush priority: next state IDLE, no DIV_DONE.
REQ-011 An 8-bit counter SHALL clear on DIV_BUSY entry and increment each DIV_BUSY cycle.
REQ-012 Counter reaching DIV_CYCLES SHALL:
- set div_timeout (sticky until reset);
- pulse div_cancel;
- return the FSM to IDLE, releasing the stall.
REQ-013 stallreq_mem during DIV_BUSY SHALL not change FSM state or the counter.

Reset
REQ-014 Asserting cpu_rst SHALL immediately force, regardless of clock: state IDLE, counter 0, div_timeout 0.
REQ-015 While cpu_rst is asserted, stall=0, flush=0, div_cancel=0 and flush_pc=EXC_VECTOR.
REQ-016 Reset in mid-divide SHALL abandon the divide with no div_cancel pulse.

Configuration
REQ-017 With macro STALL_PERF_EN defined, SHALL add these outputs:
- perf_stall_cycles  out  32: counts cycles with stall[0]==`STOP, saturating at 32'hFFFF_FFFF, reset 0.
- perf_flush_cnt  out  16: counts flush cycles, wrapping, reset 0.
REQ-018 Without STALL_PERF_EN, those ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-019 The shared defines file SHALL hold:
- `STALL_BUS, `STOP, `NOSTOP;
- `EXC_ERET;
- state encodings PC_ST_IDLE/PC_ST_DIV_BUSY/PC_ST_DIV_DONE.
REQ-020 Sub-module pipe_perf_cnt SHALL hold the STALL_PERF_EN counters; everything else stays flat.

Verification
REQ-021 Bench SHALL cover:
- stallreq_id=1 one cycle -> stall=5'b00111 that cycle, 0 next.
- div_start at T, div_ready at T+33 -> stall=5'b01111 T..T+32; 0 at T+33; DIV_DONE at T+34; IDLE at T+35.
- DIV_BUSY, exc_valid=1 with exc_code=`EXC_ERET, cp0_epc=32'h0040_0020 -> flush=1, flush_pc=32'h0040_0020, div_cancel=1, stall=0; IDLE next.
- div_start, div_ready never, DIV_CYCLES=34 -> div_timeout=1 and div_cancel pulse after 34 busy cycles; stall released.
- stallreq_mem with stallreq_id and div_start -> stall=5'b11111; after mem release -> 5'b01111.
- cpu_rst mid-divide -> state IDLE, stall=0, no div_cancel. With STALL_PERF_EN: 10 stalled cycles -> perf_stall_cycles=10.
